// File: rtl/fc_word_align_ctrl.sv
// rtl/fc_word_align_ctrl.sv - word alignment sequencer for the 8-bit fast-command deserializer
module fc_word_align_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_ERR    = 8
) (
    input  logic       clk40,
    input  logic       rst,
    input  logic       align_en,
    input  logic       manual_mode,
    input  logic [2:0] manual_phase,
    input  logic       idle_det,
    input  logic       word_valid,
    output logic [2:0] bit_phase,
    output logic       self_align_on,
    output logic       aligned,
    output logic [7:0] relock_cnt,
    output logic [2:0] ctrl_state
);

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_CONFIRM  = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_MANUAL   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERR - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [7:0] confirm_cnt;
    logic [7:0] err_cnt;
    logic       lock_loss;
    logic [7:0] relock_next;

    // A lock loss is recorded even when manual_mode preempts the relock transition.
    assign lock_loss   = (state == ST_LOCKED) && !word_valid && (err_cnt == UNLOCK_LAST);
    assign relock_next = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
    assign ctrl_state  = state;

    always_ff @(posedge clk40) begin
        if (rst) begin
            state         <= ST_DISABLED;
            bit_phase     <= 3'd0;
            self_align_on <= 1'b0;
            aligned       <= 1'b0;
            relock_cnt    <= 8'd0;
            settle_cnt    <= 4'd0;
            confirm_cnt   <= 8'd0;
            err_cnt       <= 8'd0;
        end else if (manual_mode) begin
            state         <= ST_MANUAL;
            bit_phase     <= manual_phase;
            self_align_on <= 1'b0;
            aligned       <= 1'b0;
            settle_cnt    <= 4'd0;
            confirm_cnt   <= 8'd0;
            err_cnt       <= 8'd0;
            if (lock_loss) begin
                relock_cnt <= relock_next;
            end
        end else if (!align_en) begin
            state         <= ST_DISABLED;
            self_align_on <= 1'b0;
            aligned       <= 1'b0;
            settle_cnt    <= 4'd0;
            confirm_cnt   <= 8'd0;
            err_cnt       <= 8'd0;
        end else begin
            case (state)
                ST_DISABLED, ST_MANUAL: begin
                    state         <= ST_SETTLE;
                    self_align_on <= 1'b1;
                    aligned       <= 1'b0;
                    settle_cnt    <= 4'd0;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state       <= ST_CONFIRM;
                        settle_cnt  <= 4'd0;
                        confirm_cnt <= 8'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (idle_det) begin
                        if (confirm_cnt == LOCK_LAST) begin
                            state         <= ST_LOCKED;
                            self_align_on <= 1'b0;
                            aligned       <= 1'b1;
                            confirm_cnt   <= 8'd0;
                            err_cnt       <= 8'd0;
                        end else begin
                            confirm_cnt <= confirm_cnt + 8'd1;
                        end
                    end else begin
                        // Training sends only idles, so a single miss means this tap is wrong.
                        state       <= ST_SETTLE;
                        bit_phase   <= bit_phase + 3'd1;
                        confirm_cnt <= 8'd0;
                        settle_cnt  <= 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (word_valid) begin
                        err_cnt <= 8'd0;
                    end else if (lock_loss) begin
                        state         <= ST_SETTLE;
                        self_align_on <= 1'b1;
                        aligned       <= 1'b0;
                        err_cnt       <= 8'd0;
                        settle_cnt    <= 4'd0;
                        relock_cnt    <= relock_next;
                    end else begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: begin
                    state         <= ST_DISABLED;
                    self_align_on <= 1'b0;
                    aligned       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_word_align_ctrl.sv
// tb/tb_fc_word_align_ctrl.sv - self-checking bench for fc_word_align_ctrl
module tb_fc_word_align_ctrl;

    localparam int SETTLE_CYCLES = 4;
    localparam int LOCK_COUNT    = 16;
    localparam int UNLOCK_ERR    = 8;

    logic       clk40 = 1'b0;
    logic       rst = 1'b1;
    logic       align_en = 1'b0;
    logic       manual_mode = 1'b0;
    logic [2:0] manual_phase = 3'd0;
    logic       idle_det = 1'b0;
    logic       word_valid = 1'b0;
    logic [2:0] bit_phase;
    logic       self_align_on;
    logic       aligned;
    logic [7:0] relock_cnt;
    logic [2:0] ctrl_state;

    fc_word_align_ctrl #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOCK_COUNT(LOCK_COUNT),
        .UNLOCK_ERR(UNLOCK_ERR)
    ) dut (
        .clk40(clk40),
        .rst(rst),
        .align_en(align_en),
        .manual_mode(manual_mode),
        .manual_phase(manual_phase),
        .idle_det(idle_det),
        .word_valid(word_valid),
        .bit_phase(bit_phase),
        .self_align_on(self_align_on),
        .aligned(aligned),
        .relock_cnt(relock_cnt),
        .ctrl_state(ctrl_state)
    );

    always #12 clk40 = ~clk40;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one run counter whose meaning depends on the mode
    // (cycles settled, idles seen, or consecutive bad words).
    int m_state  = 0;
    int m_phase  = 0;
    int m_relock = 0;
    int m_run    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        bit loss;
        loss = (m_state == 3) && !word_valid && (m_run + 1 == UNLOCK_ERR);
        if (rst) begin
            m_state = 0; m_phase = 0; m_relock = 0; m_run = 0;
        end else if (manual_mode) begin
            if (loss) m_relock = (m_relock < 255) ? m_relock + 1 : 255;
            m_state = 4; m_phase = int'(manual_phase); m_run = 0;
        end else if (!align_en) begin
            m_state = 0; m_run = 0;
        end else if (m_state == 0 || m_state == 4) begin
            m_state = 1; m_run = 0;
        end else if (m_state == 1) begin
            m_run++;
            if (m_run == SETTLE_CYCLES) begin m_state = 2; m_run = 0; end
        end else if (m_state == 2) begin
            if (idle_det) begin
                m_run++;
                if (m_run == LOCK_COUNT) begin m_state = 3; m_run = 0; end
            end else begin
                m_phase = (m_phase + 1) % 8; m_state = 1; m_run = 0;
            end
        end else begin
            m_run = word_valid ? 0 : m_run + 1;
            if (m_run == UNLOCK_ERR) begin
                m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                m_state = 1; m_run = 0;
            end
        end
    endtask

    task automatic tick();
        logic [31:0] exp_v;
        @(posedge clk40);
        model_step();
        #1;
        exp_v = {16'd0, 3'(m_state), 3'(m_phase), 1'(m_state == 1 || m_state == 2),
                 1'(m_state == 3), 8'(m_relock)};
        check("model", {16'd0, ctrl_state, bit_phase, self_align_on, aligned, relock_cnt}, exp_v);
    endtask

    typedef struct {
        logic       r, en, man;
        logic [2:0] mph;
        logic       idle, wv;
        int         n;
        logic [2:0] st, ph;
        logic       sa, al;
        logic [7:0] rc;
    } vec_t;

    vec_t vecs[18];
    logic [2:0] seen[$];

    task automatic hunt(input int target, input string name);
        seen = {};
        seen.push_back(bit_phase);
        for (int i = 0; i < 400 && m_state != 3; i++) begin
            idle_det = (m_phase == target);
            tick();
            if (bit_phase != seen[$]) seen.push_back(bit_phase);
        end
        check({name, "_aligned"}, 32'(aligned), 32'd1);
        check({name, "_phase"}, 32'(bit_phase), 32'(target));
    endtask

    initial begin
        //          r  en man mph   idl wv  n   st    ph    sa al rc
        vecs[0]  = '{1, 0, 0, 3'd0, 0, 0, 2,  3'd0, 3'd0, 0, 0, 8'd0};
        vecs[1]  = '{0, 1, 0, 3'd0, 1, 0, 1,  3'd1, 3'd0, 1, 0, 8'd0};
        vecs[2]  = '{0, 1, 0, 3'd0, 1, 0, 3,  3'd1, 3'd0, 1, 0, 8'd0};
        vecs[3]  = '{0, 1, 0, 3'd0, 1, 0, 1,  3'd2, 3'd0, 1, 0, 8'd0};
        vecs[4]  = '{0, 1, 0, 3'd0, 1, 0, 15, 3'd2, 3'd0, 1, 0, 8'd0};
        vecs[5]  = '{0, 1, 0, 3'd0, 1, 0, 1,  3'd3, 3'd0, 0, 1, 8'd0};
        vecs[6]  = '{0, 1, 0, 3'd0, 0, 0, 7,  3'd3, 3'd0, 0, 1, 8'd0};
        vecs[7]  = '{0, 1, 0, 3'd0, 0, 1, 1,  3'd3, 3'd0, 0, 1, 8'd0};
        vecs[8]  = '{0, 1, 0, 3'd0, 0, 0, 7,  3'd3, 3'd0, 0, 1, 8'd0};
        vecs[9]  = '{0, 1, 0, 3'd0, 0, 0, 1,  3'd1, 3'd0, 1, 0, 8'd1};
        vecs[10] = '{0, 1, 0, 3'd0, 1, 0, 4,  3'd2, 3'd0, 1, 0, 8'd1};
        vecs[11] = '{0, 1, 1, 3'd3, 1, 0, 1,  3'd4, 3'd3, 0, 0, 8'd1};
        vecs[12] = '{0, 1, 0, 3'd0, 0, 0, 1,  3'd1, 3'd3, 1, 0, 8'd1};
        vecs[13] = '{0, 0, 0, 3'd0, 0, 0, 1,  3'd0, 3'd3, 0, 0, 8'd1};
        vecs[14] = '{0, 1, 0, 3'd0, 1, 0, 20, 3'd2, 3'd3, 1, 0, 8'd1};
        vecs[15] = '{0, 0, 0, 3'd0, 1, 0, 1,  3'd0, 3'd3, 0, 0, 8'd1};
        vecs[16] = '{0, 1, 0, 3'd0, 1, 0, 21, 3'd3, 3'd3, 0, 1, 8'd1};
        vecs[17] = '{1, 1, 0, 3'd0, 1, 0, 1,  3'd0, 3'd0, 0, 0, 8'd0};

        for (int v = 0; v < 18; v++) begin
            rst = vecs[v].r; align_en = vecs[v].en; manual_mode = vecs[v].man;
            manual_phase = vecs[v].mph; idle_det = vecs[v].idle; word_valid = vecs[v].wv;
            for (int c = 0; c < vecs[v].n; c++) tick();
            check($sformatf("vec%0d", v),
                  {16'd0, ctrl_state, bit_phase, self_align_on, aligned, relock_cnt},
                  {16'd0, vecs[v].st, vecs[v].ph, vecs[v].sa, vecs[v].al, vecs[v].rc});
        end

        // Phase hunt from 0 to 5.
        rst = 1'b0; align_en = 1'b1; word_valid = 1'b0;
        hunt(5, "hunt5");
        check("hunt5_steps", 32'(seen.size()), 32'd6);
        for (int k = 0; k < seen.size() && k < 6; k++)
            check($sformatf("hunt5_seq%0d", k), 32'(seen[k]), 32'(k));
        check("hunt5_relock", 32'(relock_cnt), 32'd0);

        // Wrap-around hunt starting from phase 6.
        manual_mode = 1'b1; manual_phase = 3'd6; word_valid = 1'b1;
        tick();
        manual_mode = 1'b0;
        hunt(2, "wrap2");
        check("wrap2_steps", 32'(seen.size()), 32'd5);
        for (int k = 0; k < seen.size() && k < 5; k++)
            check($sformatf("wrap2_seq%0d", k), 32'(seen[k]), 32'((6 + k) % 8));

        // Final error coinciding with manual_mode: manual wins, loss still counted.
        word_valid = 1'b0; idle_det = 1'b0;
        repeat (UNLOCK_ERR - 1) tick();
        manual_mode = 1'b1; manual_phase = 3'd1;
        tick();
        check("loss_manual_state", 32'(ctrl_state), 32'd4);
        check("loss_manual_relock", 32'(relock_cnt), 32'd1);
        check("loss_manual_phase", 32'(bit_phase), 32'd1);
        manual_mode = 1'b0;

        // 300 lock/unlock rounds saturate relock_cnt.
        idle_det = 1'b1; word_valid = 1'b0;
        repeat (300 * (SETTLE_CYCLES + LOCK_COUNT + UNLOCK_ERR) + 2) tick();
        check("relock_sat", 32'(relock_cnt), 32'd255);

        // Randomized traffic against the model.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            int target;
            int wv_pct;
            target = (i / 500) % 8;
            wv_pct = ((i / 150) % 2 == 0) ? 95 : 25;
            rst          = ($urandom_range(0, 999) == 0);
            manual_mode  = ($urandom_range(0, 199) == 0);
            manual_phase = 3'($urandom_range(0, 7));
            align_en     = ($urandom_range(0, 99) != 0);
            idle_det     = (m_phase == target) ? ($urandom_range(0, 99) < 98)
                                               : ($urandom_range(0, 99) < 5);
            word_valid   = ($urandom_range(0, 99) < wv_pct);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
